// File: rtl/fv_pkg.sv
// Shared FV ring constants and coefficient types for the multiplier/adder datapath.
package fv_pkg;
  localparam int N     = 4;
  localparam int QW    = 5;
  localparam int Q     = 31;
  localparam int EW    = 3;
  localparam int DELTA = Q / 2;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;

  typedef logic [QW-1:0]        coeff_t;
  typedef logic [IW-1:0]        idx_t;
  typedef logic signed [QW+1:0] wide_t;
endpackage

// File: rtl/fv_ct_adder_mod_add_q.sv
// Combinational a + b mod Q for a in [0,Q-1] and signed b with |b| < Q; one correction step.
module mod_add_q
  import fv_pkg::*;
(
  input  coeff_t i_a,
  input  wide_t  i_b,
  output coeff_t o_sum
);

  localparam wide_t QS = wide_t'(Q);

  wide_t w_t;
  wide_t w_r;

  always_comb begin
    w_t = wide_t'({2'b00, i_a}) + i_b;
    w_r = w_t;
    if (w_t < 0) begin
      w_r = w_t + QS;
    end else if (w_t >= QS) begin
      w_r = w_t - QS;
    end
  end

  assign o_sum = w_r[QW-1:0];

endmodule

// File: rtl/fv_ct_adder.sv
// Joins z, e and m streams into ciphertext coefficients c = z + e + DELTA*m mod Q,
// two-stage pipeline with a generated polynomial frame and a sticky framing-error flag.
module fv_ct_adder
  import fv_pkg::*;
(
  input  logic          clk,
  input  logic          s_rst,
  input  logic          i_z_vld,
  output logic          o_z_rdy,
  input  logic          i_z_last,
  input  coeff_t        i_z_data,
  input  logic          i_e_vld,
  output logic          o_e_rdy,
  input  logic          i_e_last,
  input  logic [EW-1:0] i_e_data,
  input  logic          i_m_vld,
  output logic          o_m_rdy,
  input  logic          i_m_last,
  input  logic          i_m_data,
  output logic          o_c_vld,
  input  logic          i_c_rdy,
  output logic          o_c_last,
  output coeff_t        o_c_data,
  output logic          err_last
);

  // Handshake: a beat moves on a rising edge where vld && rdy. Each input rdy depends on
  // the other two vld (never on its own), so the three inputs are consumed together; c holds
  // data/last stable while o_c_vld && !i_c_rdy.
  logic          r_s1_vld;
  coeff_t        r_s1_sum;
  logic [EW-1:0] r_s1_e;
  logic          r_s1_last;
  logic          r_s2_vld;
  coeff_t        r_s2_data;
  logic          r_s2_last;
  idx_t          r_idx;
  logic          r_err;

  logic   w_en;
  logic   w_acc;
  logic   w_idx_last;
  logic   w_lerr;
  wide_t  w_s1_b;
  wide_t  w_s2_b;
  coeff_t w_s1_sum;
  coeff_t w_s2_sum;

  assign w_en       = !r_s2_vld || i_c_rdy;
  assign w_acc      = !s_rst && w_en && i_z_vld && i_e_vld && i_m_vld;
  assign o_z_rdy    = !s_rst && w_en && i_e_vld && i_m_vld;
  assign o_e_rdy    = !s_rst && w_en && i_z_vld && i_m_vld;
  assign o_m_rdy    = !s_rst && w_en && i_z_vld && i_e_vld;
  assign w_idx_last = (r_idx == idx_t'(N - 1));
  assign w_lerr     = (i_z_last != w_idx_last) || (i_e_last != w_idx_last) ||
                      (i_m_last != w_idx_last);
  assign w_s1_b     = i_m_data ? wide_t'(DELTA) : '0;
  assign w_s2_b     = {{(QW + 2 - EW){r_s1_e[EW-1]}}, r_s1_e};

  mod_add_q u_stage1 (
    .i_a   (i_z_data),
    .i_b   (w_s1_b),
    .o_sum (w_s1_sum)
  );

  mod_add_q u_stage2 (
    .i_a   (r_s1_sum),
    .i_b   (w_s2_b),
    .o_sum (w_s2_sum)
  );

  always_ff @(posedge clk or posedge s_rst) begin
    if (s_rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_sum  <= '0;
      r_s1_e    <= '0;
      r_s1_last <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s2_data <= '0;
      r_s2_last <= 1'b0;
      r_idx     <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_en) begin
        r_s2_vld  <= r_s1_vld;
        r_s2_data <= w_s2_sum;
        r_s2_last <= r_s1_last;
        r_s1_vld  <= w_acc;
      end
      if (w_acc) begin
        r_s1_sum  <= w_s1_sum;
        r_s1_e    <= i_e_data;
        r_s1_last <= w_idx_last;
        r_idx     <= w_idx_last ? '0 : idx_t'(r_idx + 1'b1);
        if (w_lerr) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign o_c_vld  = r_s2_vld;
  assign o_c_last = r_s2_last;
  assign o_c_data = r_s2_data;
  assign err_last = r_err;

endmodule
